// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB-first, valid/ready in and out
// Optional subtract path (A-B via ~B and carry-in 1) enabled by SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Two half-adder slices: operand bits first, then the registered carry.
  logic ha0_s, ha0_c, ha1_s, ha1_c;
  assign ha0_s = ra_q[0] ^ rb_q[0];
  assign ha0_c = ra_q[0] & rb_q[0];
  assign ha1_s = ha0_s ^ c_q;
  assign ha1_c = ha0_s & c_q;

  logic [WIDTH-1:0] rb_load;
  logic             c_load;
`ifdef SERIAL_ADDER_SUB_EN
  assign rb_load = Sub ? ~B : B;
  assign c_load  = Sub ? 1'b1 : CarryIn;
`else
  assign rb_load = B;
  assign c_load  = CarryIn;
`endif

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ra_d    = A;
          rb_d    = rb_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ra_d  = {1'b0, ra_q[WIDTH-1:1]};
        rb_d  = {1'b0, rb_q[WIDTH-1:1]};
        sum_d = {ha1_s, sum_q[WIDTH-1:1]};
        c_d   = ha0_c | ha1_c;
        // Counter holds at LAST on the final edge so it never wraps.
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Busy      = (state_q == SHIFT);
  assign Sum       = sum_q;
  assign CarryOut  = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8)
// Build with SERIAL_ADDER_SUB_EN defined to also exercise subtraction.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CarryIn = 1'b0;
  logic         Sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] Sum;
  logic         CarryOut;
  logic         Busy;

  int cmp = 0;
  int mis = 0;
  int cyc = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .CarryIn(CarryIn),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(Sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum(Sum),
    .CarryOut(CarryOut),
    .Busy(Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain (W+1)-bit arithmetic; subtraction is A + ~B + 1.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic sub);
    logic [W:0] r;
    if (sub) r = {1'b0, a} + {1'b0, W'(~b)} + (W+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    cmp++;
    if ({in_ready, out_valid, Busy, CarryOut, Sum} !== {3'b100, 1'b0, 8'h00}) begin
      mis++;
      $display("FAIL reset_state: got rdy/ov/busy/co/sum=%b%b%b%b/%h want 1000/00",
               in_ready, out_valid, Busy, CarryOut, Sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // One full operation: accept, WIDTH shift cycles, check result, handshake out.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sub, input int hold, input string nm);
    logic [W:0] exp;
    int busy_n;
    int guard;
    exp = model(a, b, ci, sub);
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    A = a; B = b; CarryIn = ci; Sub = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = $urandom; B = $urandom; CarryIn = $urandom_range(0, 1);
    busy_n = 0;
    for (int i = 0; i < W; i++) begin
      if (Busy) busy_n++;
      cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        mis++;
        $display("FAIL %s_early: cycle %0d ov=%b rdy=%b want 0/0", nm, i, out_valid, in_ready);
      end
      tick();
    end
    cmp++;
    if (busy_n != W || Busy !== 1'b0) begin
      mis++;
      $display("FAIL %s_busy: busy cycles %0d (busy now %b) want %0d", nm, busy_n, Busy, W);
    end
    for (int i = 0; i <= hold; i++) begin
      cmp++;
      if (out_valid !== 1'b1 || {CarryOut, Sum} !== exp) begin
        mis++;
        $display("FAIL %s_result: ov=%b co/sum=%b/%h want 1 %b/%h",
                 nm, out_valid, CarryOut, Sum, exp[W], exp[W-1:0]);
      end
      if (i < hold) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {CarryOut, Sum} !== exp) begin
      mis++;
      $display("FAIL %s_release: rdy=%b ov=%b co/sum=%b/%h want 1 0 %b/%h",
               nm, in_ready, out_valid, CarryOut, Sum, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_add();
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 0, "add_5a_33");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1, "add_ff_01");
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, "add_ff_ff_c");
    run_op(8'h00, 8'h00, 1'b0, 1'b0, 0, "add_zero");
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0,
             $urandom_range(0, 3), "add_rand");
  endtask

  task automatic test_backpressure();
    logic [W:0] held;
    A = 8'h5A; B = 8'h33; CarryIn = 1'b0; in_valid = 1'b1;
    tick();
    A = 8'h11; B = 8'h22; CarryIn = 1'b0;
    for (int i = 0; i < W; i++) tick();
    held = {CarryOut, Sum};
    cmp++;
    if (held !== 9'h08D || out_valid !== 1'b1) begin
      mis++;
      $display("FAIL bp_done: ov=%b co/sum=%h want 1 08d", out_valid, held);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp++;
      if ({CarryOut, Sum} !== 9'h08D || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        mis++;
        $display("FAIL bp_hold: cycle %0d co/sum=%h rdy=%b ov=%b want 08d 0 1",
                 i, {CarryOut, Sum}, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    cmp++;
    if (in_ready !== 1'b1 || Busy !== 1'b0) begin
      mis++;
      $display("FAIL bp_idle: rdy=%b busy=%b want 1 0", in_ready, Busy);
    end
    tick();
    in_valid = 1'b0;
    cmp++;
    if (Busy !== 1'b1) begin
      mis++;
      $display("FAIL bp_accept: busy=%b want 1", Busy);
    end
    for (int i = 0; i < W; i++) tick();
    cmp++;
    if (out_valid !== 1'b1 || {CarryOut, Sum} !== 9'h033) begin
      mis++;
      $display("FAIL bp_second: ov=%b co/sum=%h want 1 033", out_valid, {CarryOut, Sum});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    A = 8'h5A; B = 8'h33; CarryIn = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    cmp++;
    if ({in_ready, out_valid, Busy, CarryOut, Sum} !== {3'b100, 1'b0, 8'h00}) begin
      mis++;
      $display("FAIL midop_reset: rdy/ov/busy/co/sum=%b%b%b%b/%h want 1000/00",
               in_ready, out_valid, Busy, CarryOut, Sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [W:0] expq[$];
    logic [W-1:0] pa[3];
    logic [W-1:0] pb[3];
    int idx;
    int got;
    int last_cyc;
    bit acc;
    for (int i = 0; i < 3; i++) begin pa[i] = W'($urandom); pb[i] = W'($urandom); end
    idx = 0; got = 0; last_cyc = -1;
    out_ready = 1'b1;
    A = pa[0]; B = pb[0]; CarryIn = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 200 && got < 3; t++) begin
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        expq.push_back(model(A, B, 1'b0, 1'b0));
        idx++;
        if (idx < 3) begin A = pa[idx]; B = pb[idx]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        cmp++;
        if (expq.size() == 0 || {CarryOut, Sum} !== expq[0]) begin
          mis++;
          $display("FAIL b2b_result%0d: co/sum=%h want %h", got, {CarryOut, Sum},
                   expq.size() ? expq[0] : 9'h0);
        end
        if (expq.size() != 0) void'(expq.pop_front());
        if (last_cyc >= 0) begin
          cmp++;
          if (cyc - last_cyc != W + 2) begin
            mis++;
            $display("FAIL b2b_spacing%0d: %0d cycles want %0d", got, cyc - last_cyc, W + 2);
          end
        end
        last_cyc = cyc;
        got++;
      end
    end
    cmp++;
    if (got != 3) begin
      mis++;
      $display("FAIL b2b_count: got %0d results want 3", got);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, "sub_10_01");
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 0, "sub_01_02");
    for (int i = 0; i < 10; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1, 0, "sub_rand");
    Sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
